blk_mem_stream_reader: RTL

- Read-side master for the on-chip single-port block RAM model, whose read latency is 2 cycles.
- Takes a (base, length) burst command, issues sequential read addresses on the RAM port and returns the read data as a valid/ready stream.
- A small credit-controlled output FIFO absorbs downstream backpressure, so no RAM read result is ever lost.
- Sits between weight/activation buffers and streaming compute cores.

---
 rtl/memory_pkg.sv | 15 +
 rtl/blk_mem_reader_fifo.sv | 53 +++++
 rtl/blk_mem_stream_reader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared types for the block-RAM stream reader: controller states and the
// address-width rule that matches the RAM model.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int addr_width(input int mem_size);
    return $clog2(mem_size) + 1;
  endfunction

endpackage

// File: rtl/blk_mem_reader_fifo.sv
// Small synchronous FIFO that buffers RAM read data ahead of the output stream.
// Head is presented combinationally; push while full or pop while empty is ignored.
module blk_mem_reader_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic [CW-1:0]         o_count
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push  = i_push && (r_count != CW'(FIFO_DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/blk_mem_stream_reader.sv
// Burst read master for the 2-cycle-latency block RAM; streams words out through
// a credit-controlled FIFO so RAM results are never dropped under backpressure.
module blk_mem_stream_reader
  import memory_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int MEM_SIZE   = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = addr_width(MEM_SIZE),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  input  logic [DATA_WIDTH-1:0] mem_douta
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [1:0]            r_vld_pipe;
  logic                  r_done;
  logic                  w_issue;
  logic                  w_latch;
  logic                  w_done_nxt;
  logic                  w_credit;
  logic [CW:0]           w_occupancy;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_pop;

  blk_mem_reader_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_vld_pipe[1]),
    .i_data (mem_douta),
    .i_pop  (w_pop),
    .o_data (data_out),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

  assign mem_ena        = (r_state != IDLE);
  assign busy           = (r_state != IDLE);
  assign mem_wea        = 1'b0;
  assign mem_addra      = r_addr;
  assign done           = r_done;
  assign data_out_valid = !w_fifo_empty;
  assign w_pop          = data_out_valid && data_out_ready;

  // Buffered plus in-flight words; this cycle's pop is deliberately not credited.
  assign w_occupancy = {1'b0, w_fifo_count} + (CW+1)'(r_vld_pipe[0]) + (CW+1)'(r_vld_pipe[1]);
  assign w_credit    = (w_occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_latch     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            w_latch     = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_remaining == LEN_WIDTH'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_vld_pipe == 2'b00) && w_fifo_empty) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_vld_pipe  <= 2'b00;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_latch) begin
        r_addr      <= base_addr;
        r_remaining <= length;
      end else if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      // Tracks the RAM pipeline, which only moves while enabled.
      if (mem_ena) r_vld_pipe <= {r_vld_pipe[0], w_issue};
    end
  end

endmodule
